// File: rtl/instr_fetch_ctrl_if.sv
// Fetch bus: instruction-memory address/data plus the decode valid/ready handshake.
// The fetch controller takes the master side; memory and decode sit on the slave side.
interface instr_fetch_ctrl_if #(
  parameter int PC_W = 5,
  parameter int IW   = 32
);
  logic [PC_W-1:0] PC;
  logic [IW-1:0]   IR;
  logic [IW-1:0]   instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    output PC,
    input  IR,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  PC,
    output IR,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: drives PC into a combinational instruction memory, registers the word
// for decode, applies taken-branch redirects and halts after a run of accepted nop words.
// Optional FETCH_PERF_CNT_EN enables the saturating accepted-instruction counter.
module instr_fetch_ctrl #(
  parameter int PC_W      = 5,
  parameter int IW        = 32,
  parameter int HALT_NOPS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  instr_fetch_ctrl_if.master     bus,
  input  logic                   br_taken,
  input  logic [PC_W-1:0]        br_pc,
  input  logic signed [15:0]     br_offset,
  output logic                   halted,
  output logic [15:0]            fetch_count
);

  localparam int NOP_W = $clog2(HALT_NOPS + 1);
  localparam logic [NOP_W-1:0] NOP_LAST = NOP_W'(HALT_NOPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state_q, state_nxt;
  logic [PC_W-1:0]   pc_p0, pc_p0_nxt;
  logic [IW-1:0]     instr_p1, instr_p1_nxt;
  logic [PC_W-1:0]   instr_pc_p1, instr_pc_p1_nxt;
  logic              vld_p1, vld_p1_nxt;
  logic [NOP_W-1:0]  nop_run, nop_run_nxt;

  logic hs;
  logic load;
  logic is_nop;

  assign hs     = vld_p1 & bus.instr_ready;
  assign load   = ~vld_p1 | bus.instr_ready;
  assign is_nop = (instr_p1 == '0);

  always_comb begin
    state_nxt       = state_q;
    pc_p0_nxt       = pc_p0;
    instr_p1_nxt    = instr_p1;
    instr_pc_p1_nxt = instr_pc_p1;
    vld_p1_nxt      = vld_p1;
    nop_run_nxt     = nop_run;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt   = S_FETCH;
          pc_p0_nxt   = '0;
          vld_p1_nxt  = 1'b0;
          nop_run_nxt = '0;
        end
      end
      S_FETCH: begin
        if (br_taken) begin
          // Target is relative to the word after the branch; only the low PC_W bits matter.
          pc_p0_nxt   = PC_W'(16'(br_pc) + 16'd1 + br_offset);
          vld_p1_nxt  = 1'b0;
          nop_run_nxt = '0;
        end else begin
          if (hs) begin
            nop_run_nxt = is_nop ? nop_run + NOP_W'(1) : '0;
          end
          if (hs && is_nop && (nop_run == NOP_LAST)) begin
            state_nxt  = S_HALT;
            vld_p1_nxt = 1'b0;
          end else if (load) begin
            instr_p1_nxt    = bus.IR;
            instr_pc_p1_nxt = pc_p0;
            vld_p1_nxt      = 1'b1;
            pc_p0_nxt       = pc_p0 + PC_W'(1);
          end
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        vld_p1_nxt = 1'b0;
      end
    endcase
  end

  // p0: PC / control state; p1: instruction register presented to decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_p0       <= '0;
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
      vld_p1      <= 1'b0;
      nop_run     <= '0;
    end else begin
      state_q     <= state_nxt;
      pc_p0       <= pc_p0_nxt;
      instr_p1    <= instr_p1_nxt;
      instr_pc_p1 <= instr_pc_p1_nxt;
      vld_p1      <= vld_p1_nxt;
      nop_run     <= nop_run_nxt;
    end
  end

  assign bus.PC          = pc_p0;
  assign bus.instr       = instr_p1;
  assign bus.instr_pc    = instr_pc_p1;
  assign bus.instr_valid = vld_p1;
  assign halted          = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] perf_cnt;
  logic        perf_clr;
  logic        perf_inc;

  // A squashing redirect suppresses the accept in the same cycle.
  assign perf_clr = (state_q != S_FETCH) & start;
  assign perf_inc = (state_q == S_FETCH) & ~br_taken & hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (perf_clr) begin
      perf_cnt <= '0;
    end else if (perf_inc) begin
      perf_cnt <= sat_inc16(perf_cnt);
    end
  end

  assign fetch_count = perf_cnt;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: reset/idle, straight-line fetch, stall, loop branch,
// nop halt, restart, async reset mid-stall, and PC wrap with a long nop-halt threshold.
module tb_instr_fetch_ctrl;
  localparam int PC_W = 5;
  localparam int IW   = 32;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic br_taken = 1'b0;
  logic [PC_W-1:0] br_pc = '0;
  logic signed [15:0] br_offset = '0;
  logic halted, halted2;
  logic [15:0] fetch_count, fetch_count2;
  logic [IW-1:0] mem [32];

  int checks = 0;
  int failures = 0;

  instr_fetch_ctrl_if #(.PC_W(PC_W), .IW(IW)) bif ();
  instr_fetch_ctrl_if #(.PC_W(PC_W), .IW(IW)) bif2 ();

  assign bif.IR = mem[bif.PC];
  assign bif2.IR = '0;
  assign bif2.instr_ready = 1'b1;

  instr_fetch_ctrl #(.PC_W(PC_W), .IW(IW), .HALT_NOPS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bif.master),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_offset   (br_offset),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  instr_fetch_ctrl #(.PC_W(PC_W), .IW(IW), .HALT_NOPS(40)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start2),
    .bus         (bif2.master),
    .br_taken    (1'b0),
    .br_pc       (5'd0),
    .br_offset   (16'sd0),
    .halted      (halted2),
    .fetch_count (fetch_count2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fc(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    bif.instr_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = (i < 8) ? (32'hA000_0000 + 32'(i)) : 32'h0;

    // Reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", 32'(bif.PC), 0);
    chk("rst_vld", 32'(bif.instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_cnt", 32'(fetch_count), 0);
    #2 rst_n = 1'b1;

    // Idle without start
    repeat (3) step();
    chk("idle_pc", 32'(bif.PC), 0);
    chk("idle_vld", 32'(bif.instr_valid), 0);
    chk("idle_halted", 32'(halted), 0);
    chk("idle_instr", bif.instr, 0);

    // Start and straight-line fetch
    start = 1'b1;
    bif.instr_ready = 1'b1;
    step();
    start = 1'b0;
    chk("start_pc", 32'(bif.PC), 0);
    chk("start_vld", 32'(bif.instr_valid), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("line_pc", 32'(bif.PC), 32'(k));
      chk("line_ipc", 32'(bif.instr_pc), 32'(k - 1));
      chk("line_instr", bif.instr, 32'hA000_0000 + 32'(k - 1));
      chk("line_vld", 32'(bif.instr_valid), 1);
    end

    // Stall three clocks while instr_pc=4
    bif.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", 32'(bif.PC), 5);
      chk("stall_ipc", 32'(bif.instr_pc), 4);
      chk("stall_instr", bif.instr, 32'hA000_0004);
      chk("stall_vld", 32'(bif.instr_valid), 1);
    end
    chk("stall_cnt", 32'(fetch_count), fc(4));

    bif.instr_ready = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      step();
      chk("resume_pc", 32'(bif.PC), 32'(k));
      chk("resume_ipc", 32'(bif.instr_pc), 32'(k - 1));
    end
    chk("pre_br_cnt", 32'(fetch_count), fc(7));

    // Loop branch at 7 with offset -5 -> target 3
    br_taken = 1'b1;
    br_pc = 5'd7;
    br_offset = 16'shFFFB;
    step();
    br_taken = 1'b0;
    chk("br_pc", 32'(bif.PC), 3);
    chk("br_vld", 32'(bif.instr_valid), 0);
    chk("br_cnt", 32'(fetch_count), fc(7));
    step();
    chk("br_tgt_ipc", 32'(bif.instr_pc), 3);
    chk("br_tgt_pc", 32'(bif.PC), 4);
    chk("br_tgt_vld", 32'(bif.instr_valid), 1);
    chk("br_tgt_instr", bif.instr, 32'hA000_0003);

    // Run into the nop words at 8 and 9
    for (int k = 4; k <= 9; k++) begin
      step();
      chk("run_ipc", 32'(bif.instr_pc), 32'(k));
      chk("run_pc", 32'(bif.PC), 32'(k + 1));
      if (k == 6) chk("cnt10", 32'(fetch_count), fc(10));
    end
    chk("nop9_instr", bif.instr, 0);
    chk("nop9_vld", 32'(bif.instr_valid), 1);
    chk("nop9_halted", 32'(halted), 0);
    step();
    chk("halt_halted", 32'(halted), 1);
    chk("halt_vld", 32'(bif.instr_valid), 0);
    chk("halt_pc", 32'(bif.PC), 10);
    chk("halt_ipc", 32'(bif.instr_pc), 9);
    chk("halt_cnt", 32'(fetch_count), fc(14));

    // Branch ignored while halted
    br_taken = 1'b1;
    br_pc = 5'd0;
    br_offset = 16'sd3;
    repeat (3) step();
    br_taken = 1'b0;
    chk("halt_br_pc", 32'(bif.PC), 10);
    chk("halt_br_vld", 32'(bif.instr_valid), 0);
    chk("halt_br_halted", 32'(halted), 1);

    // Restart from HALT
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_pc", 32'(bif.PC), 0);
    chk("restart_vld", 32'(bif.instr_valid), 0);
    chk("restart_halted", 32'(halted), 0);
    chk("restart_cnt", 32'(fetch_count), 0);
    repeat (3) step();
    chk("restart_ipc", 32'(bif.instr_pc), 2);
    bif.instr_ready = 1'b0;
    step();
    chk("restall_pc", 32'(bif.PC), 3);
    chk("restall_ipc", 32'(bif.instr_pc), 2);
    chk("restall_cnt", 32'(fetch_count), fc(2));

    // Async reset mid-stall, between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(bif.PC), 0);
    chk("arst_instr", bif.instr, 0);
    chk("arst_ipc", 32'(bif.instr_pc), 0);
    chk("arst_vld", 32'(bif.instr_valid), 0);
    chk("arst_halted", 32'(halted), 0);
    chk("arst_cnt", 32'(fetch_count), 0);
    step();
    #2 rst_n = 1'b1;
    repeat (2) step();
    chk("post_arst_pc", 32'(bif.PC), 0);
    chk("post_arst_vld", 32'(bif.instr_valid), 0);

    // Second instance: all-zero program, HALT_NOPS=40, PC wraps
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("w_start_pc", 32'(bif2.PC), 0);
    repeat (31) step();
    chk("w_pc31", 32'(bif2.PC), 31);
    chk("w_ipc30", 32'(bif2.instr_pc), 30);
    chk("w_vld", 32'(bif2.instr_valid), 1);
    chk("w_halted0", 32'(halted2), 0);
    step();
    chk("w_wrap_pc", 32'(bif2.PC), 0);
    chk("w_wrap_ipc", 32'(bif2.instr_pc), 31);
    repeat (8) step();
    chk("w_prehalt", 32'(halted2), 0);
    chk("w_prehalt_pc", 32'(bif2.PC), 8);
    step();
    chk("w_halted", 32'(halted2), 1);
    chk("w_halt_vld", 32'(bif2.instr_valid), 0);
    chk("w_halt_pc", 32'(bif2.PC), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
